// File: rtl/mydemux_pkg.sv
// Shared encodings and parameter derivations for the 1:2 TDM demultiplexer.
package mydemux_pkg;

    // Frame state encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SLOT1 = 2'd1;
    localparam logic [1:0] ST_SLOT2 = 2'd2;

    // Error counter width when the error-count option is built in.
    localparam int unsigned ERRCNT_W = 8;

    // Slot-cycle counter width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned slot_cycles);
        int unsigned w;
        w = 32'($clog2(slot_cycles));
        return (w < 1) ? 1 : w;
    endfunction

    // Cycle within a slot at which the line is sampled.
    function automatic int unsigned sample_idx(input int unsigned slot_cycles);
        return slot_cycles / 2;
    endfunction

    // Width of the missing-sync counter so that it can hold miss_max.
    function automatic int unsigned miss_width(input int unsigned miss_max);
        int unsigned w;
        w = 32'($clog2(miss_max + 1));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mydemux_slot_cnt.sv
// Wrapping slot-cycle counter with synchronous clear and terminal-count flag.
module mydemux_slot_cnt #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    // Terminal count: last cycle of the slot.
    assign tc_c = (cnt == W'(MAX - 1));

    // Count while running, wrap at terminal count, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc_c ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/mydemux1_2_tdm.sv
// Receive side of the 2:1 TDM link: locks to frame sync, samples each slot
// mid-way and presents two registered channels with one-cycle strobes.
// Optional error counter (err_cnt/clr_cnt) is built when MYDEMUX_ERRCNT_EN
// is defined.
module mydemux1_2_tdm
    import mydemux_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SLOT_CYCLES = 4,
    parameter int unsigned MISS_MAX    = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                en,
    input  logic [WIDTH-1:0]    in,
    input  logic                sync,
`ifdef MYDEMUX_ERRCNT_EN
    input  logic                clr_cnt,
    output logic [ERRCNT_W-1:0] err_cnt,
`endif
    output logic [WIDTH-1:0]    out1,
    output logic [WIDTH-1:0]    out2,
    output logic                out1_vld,
    output logic                out2_vld,
    output logic                slot,
    output logic                locked,
    output logic                sync_err
);

    localparam int unsigned CNT_W   = cnt_width(SLOT_CYCLES);
    localparam int unsigned SMP_IDX = sample_idx(SLOT_CYCLES);
    localparam int unsigned MISS_W  = miss_width(MISS_MAX);

    logic [1:0]        state;
    logic [1:0]        nxt_state;
    logic [MISS_W-1:0] miss;
    logic [MISS_W-1:0] nxt_miss;
    logic [MISS_W-1:0] miss_inc_c;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_tc_c;
    logic              cnt_clr_c;
    logic              cnt_run_c;
    logic              at_smp_c;
    logic              sync_due_c;
    logic              smp1_c;
    logic              smp2_c;
    logic              err_c;

    assign cnt_run_c  = (state != ST_IDLE);
    assign at_smp_c   = (cnt == CNT_W'(SMP_IDX));
    assign sync_due_c = (state == ST_SLOT2) && cnt_tc_c;
    assign miss_inc_c = miss + MISS_W'(1);

    // Slot-cycle counter.
    mydemux_slot_cnt #(
        .MAX (SLOT_CYCLES),
        .W   (CNT_W)
    ) u_slot_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .inc   (cnt_run_c),
        .clr   (cnt_clr_c),
        .cnt   (cnt),
        .tc_c  (cnt_tc_c)
    );

    // State and missing-sync registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
            miss  <= '0;
        end else begin
            state <= nxt_state;
            miss  <= nxt_miss;
        end
    end

    // Next-state, sampling and sync-check decisions.
    always_comb begin
        nxt_state = state;
        nxt_miss  = miss;
        cnt_clr_c = 1'b0;
        smp1_c    = 1'b0;
        smp2_c    = 1'b0;
        err_c     = 1'b0;
        if (!en) begin
            nxt_state = ST_IDLE;
            nxt_miss  = '0;
            cnt_clr_c = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_clr_c = 1'b1;
                    nxt_miss  = '0;
                    if (sync) begin
                        nxt_state = ST_SLOT1;
                    end
                end
                ST_SLOT1, ST_SLOT2: begin
                    if (sync && !sync_due_c) begin
                        // Misplaced sync: restart the frame, drop this slot's sample.
                        err_c     = 1'b1;
                        nxt_state = ST_SLOT1;
                        nxt_miss  = '0;
                        cnt_clr_c = 1'b1;
                    end else begin
                        smp1_c = (state == ST_SLOT1) && at_smp_c;
                        smp2_c = (state == ST_SLOT2) && at_smp_c;
                        if (cnt_tc_c) begin
                            if (state == ST_SLOT1) begin
                                nxt_state = ST_SLOT2;
                            end else if (sync) begin
                                nxt_state = ST_SLOT1;
                                nxt_miss  = '0;
                            end else if (miss_inc_c == MISS_W'(MISS_MAX)) begin
                                nxt_state = ST_IDLE;
                                nxt_miss  = '0;
                                cnt_clr_c = 1'b1;
                            end else begin
                                nxt_state = ST_SLOT1;
                                nxt_miss  = miss_inc_c;
                            end
                        end
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                    nxt_miss  = '0;
                    cnt_clr_c = 1'b1;
                end
            endcase
        end
    end

    // Registered channel outputs, strobes and status.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out1     <= '0;
            out2     <= '0;
            out1_vld <= 1'b0;
            out2_vld <= 1'b0;
            slot     <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (smp1_c) begin
                out1 <= in;
            end
            if (smp2_c) begin
                out2 <= in;
            end
            out1_vld <= smp1_c;
            out2_vld <= smp2_c;
            slot     <= (nxt_state == ST_SLOT2);
            locked   <= (nxt_state != ST_IDLE);
            sync_err <= err_c;
        end
    end

`ifdef MYDEMUX_ERRCNT_EN
    logic err_evt_c;

    // Error event: misplaced sync, or leaving lock while enabled (flywheel exhausted).
    assign err_evt_c = err_c || (en && (state != ST_IDLE) && (nxt_state == ST_IDLE));

    // Saturating error counter; clear beats increment.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (err_evt_c && (err_cnt != {ERRCNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mydemux1_2_tdm.sv
// Scoreboard bench for mydemux1_2_tdm (WIDTH=1, SLOT_CYCLES=4, MISS_MAX=3).
module tb_mydemux1_2_tdm;

    localparam int unsigned WIDTH = 1;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             en;
    logic             sync;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic             out1_vld;
    logic             out2_vld;
    logic             slot;
    logic             locked;
    logic             sync_err;
`ifdef MYDEMUX_ERRCNT_EN
    logic             clr_cnt;
    logic [7:0]       err_cnt;
`endif

    typedef struct {
        bit               ch;
        logic [WIDTH-1:0] val;
        int               at;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    mydemux1_2_tdm #(
        .WIDTH       (WIDTH),
        .SLOT_CYCLES (4),
        .MISS_MAX    (3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .in        (din),
        .sync      (sync),
`ifdef MYDEMUX_ERRCNT_EN
        .clr_cnt   (clr_cnt),
        .err_cnt   (err_cnt),
`endif
        .out1      (out1),
        .out2      (out2),
        .out1_vld  (out1_vld),
        .out2_vld  (out2_vld),
        .slot      (slot),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input bit ch, input logic [WIDTH-1:0] v, input int at);
        exp_t e;
        e.ch  = ch;
        e.val = v;
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic sb_check(input bit ch, input logic [WIDTH-1:0] v);
        exp_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL strobe_unexpected: ch%0d val %0h at cycle %0d, required no strobe", ch, v, cyc);
        end else begin
            e = q.pop_front();
            if (e.ch != ch || e.val !== v || e.at != cyc) begin
                fails++;
                $display("FAIL strobe: got ch%0d val %0h at cycle %0d, required ch%0d val %0h at cycle %0d",
                         ch, v, cyc, e.ch, e.val, e.at);
            end
        end
    endtask

    // Monitor: consume expectations whenever a strobe appears.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            while (q.size() > 0 && q[0].at < cyc) begin
                tests++;
                fails++;
                $display("FAIL strobe_missing: ch%0d val %0h due cycle %0d, none by cycle %0d",
                         q[0].ch, q[0].val, q[0].at, cyc);
                q.delete(0);
            end
            if (out1_vld) sb_check(1'b0, out1);
            if (out2_vld) sb_check(1'b1, out2);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        en        = 1'b1;
        sync      = 1'b0;
        din       = '0;
`ifdef MYDEMUX_ERRCNT_EN
        clr_cnt   = 1'b0;
`endif
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    // Lock with sync at 0 and 8; out1=1 strobed at 4, out2=0 strobed at 8.
    task automatic scn_lock();
        logic [15:0] sm;
        logic [15:0] dp;
        sm = 16'h0101;
        dp = 16'h0148;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) begin
                push(1'b0, 1'b1, cyc + 4);
                push(1'b1, 1'b0, cyc + 8);
                chk("s1_locked_pre", 32'(locked), 0);
            end else begin
                chk("s1_locked", 32'(locked), 1);
            end
            chk("s1_sync_err", 32'(sync_err), 0);
            sync = sm[c];
            din  = dp[c];
        end
    endtask

    // Free-running frame: sample k lands at 4k+3 and strobes at 4k+4 on ch k%2.
    task automatic scn_fly(input logic [7:0] v, input logic [63:0] sm, input int n,
                           input int nstrobe, input int lose_at);
        int k;
        bit lk;
        for (int c = 0; c < n; c++) begin
            tick();
            if (c == 0) begin
                for (int j = 0; j < nstrobe; j++) push(j[0], v[j], cyc + 4 * j + 4);
            end
            lk = (c >= 1) && (lose_at < 0 || c < lose_at);
            chk("fly_locked", 32'(locked), 32'(lk));
            chk("fly_sync_err", 32'(sync_err), 0);
            k    = (c - 1) / 4;
            sync = sm[c];
            din  = (c % 4 == 3) ? v[k] : ~v[k];
        end
    endtask

    initial begin
        logic [31:0] sm;
        logic [31:0] dp;
        sys_rst_n = 1'b0;
        en        = 1'b0;
        sync      = 1'b0;
        din       = '0;
`ifdef MYDEMUX_ERRCNT_EN
        clr_cnt   = 1'b0;
`endif
        do_reset();

        // Reset state.
        chk("rst_out1", 32'(out1), 0);
        chk("rst_out2", 32'(out2), 0);
        chk("rst_out1_vld", 32'(out1_vld), 0);
        chk("rst_out2_vld", 32'(out2_vld), 0);
        chk("rst_slot", 32'(slot), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_sync_err", 32'(sync_err), 0);
`ifdef MYDEMUX_ERRCNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 0);
`endif

        // Lock and sample.
        scn_lock();
        chk("s1_pending", q.size(), 0);
        do_reset();

        // Flywheel over two missing syncs, resync at 24.
        scn_fly(8'h33, 64'h0000_0000_0100_0001, 30, 7, -1);
        chk("s2_pending", q.size(), 0);
        do_reset();

        // Three missing syncs: lock lost at cycle 25, outputs hold.
        scn_fly(8'h2D, 64'h0000_0000_0000_0001, 32, 6, 25);
        chk("s3_hold_out1", 32'(out1), 0);
        chk("s3_hold_out2", 32'(out2), 1);
        chk("s3_pending", q.size(), 0);
`ifdef MYDEMUX_ERRCNT_EN
        chk("s3_err_cnt", 32'(err_cnt), 1);
`endif
        do_reset();

        // Misplaced syncs at 6 (SLOT2) and 17 (SLOT1 sample cycle).
        sm = 32'h0002_4041;
        dp = 32'h0012_2588;
        for (int c = 0; c < 23; c++) begin
            tick();
            if (c == 0) begin
                push(1'b0, 1'b1, cyc + 4);
                push(1'b0, 1'b0, cyc + 10);
                push(1'b1, 1'b1, cyc + 14);
                push(1'b0, 1'b1, cyc + 21);
            end
            if (c == 6) begin
                chk("s4_slot_c6", 32'(slot), 1);
                chk("s4_err_c6", 32'(sync_err), 0);
            end
            if (c == 7) begin
                chk("s4_err_c7", 32'(sync_err), 1);
                chk("s4_slot_c7", 32'(slot), 0);
            end
            if (c == 8) begin
                chk("s4_err_c8", 32'(sync_err), 0);
`ifdef MYDEMUX_ERRCNT_EN
                chk("s4_err_cnt_c8", 32'(err_cnt), 1);
`endif
            end
            if (c == 15) chk("s4_err_c15", 32'(sync_err), 0);
            if (c == 18) begin
                chk("s4_err_c18", 32'(sync_err), 1);
                chk("s4_out1_hold", 32'(out1), 0);
            end
`ifdef MYDEMUX_ERRCNT_EN
            if (c == 19) chk("s4_err_cnt_c19", 32'(err_cnt), 2);
`endif
            sync = sm[c];
            din  = dp[c];
        end
        chk("s4_pending", q.size(), 0);
        do_reset();

        // Enable drop at 3 (sync ignored), relock at 6, async reset mid-SLOT2.
        sm = 32'h0000_0049;
        dp = 32'h0000_2208;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (c == 0) push(1'b0, 1'b1, cyc + 10);
            if (c == 3) chk("s5_locked_c3", 32'(locked), 1);
            if (c == 4) begin
                chk("s5_locked_c4", 32'(locked), 0);
                chk("s5_slot_c4", 32'(slot), 0);
                chk("s5_out1_c4", 32'(out1), 0);
            end
            if (c == 5) chk("s5_locked_c5", 32'(locked), 0);
            if (c == 7) chk("s5_locked_c7", 32'(locked), 1);
            if (c == 14) begin
                chk("s5_out2_vld_c14", 32'(out2_vld), 1);
                chk("s5_out2_c14", 32'(out2), 1);
                chk("s5_slot_c14", 32'(slot), 1);
                chk("s5_pending", q.size(), 0);
                sys_rst_n = 1'b0;
                #1;
                chk("s5_rst_out1", 32'(out1), 0);
                chk("s5_rst_out2", 32'(out2), 0);
                chk("s5_rst_out2_vld", 32'(out2_vld), 0);
                chk("s5_rst_slot", 32'(slot), 0);
                chk("s5_rst_locked", 32'(locked), 0);
            end else begin
                en   = (c != 3);
                sync = sm[c];
                din  = dp[c];
            end
        end
        do_reset();
        scn_lock();
        chk("s5_relock_pending", q.size(), 0);

`ifdef MYDEMUX_ERRCNT_EN
        do_reset();
        // 301 misplaced syncs saturate err_cnt; clear wins over a same-cycle error.
        for (int c = 0; c < 303; c++) begin
            tick();
            if (c == 2) chk("s6_err_cnt_c2", 32'(err_cnt), 1);
            if (c == 301) chk("s6_err_cnt_sat", 32'(err_cnt), 255);
            if (c == 302) begin
                chk("s6_err_cnt_clr", 32'(err_cnt), 0);
                chk("s6_sync_err_c302", 32'(sync_err), 1);
            end
            sync    = (c <= 301);
            clr_cnt = (c == 301);
        end
        chk("s6_pending", q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
